// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: core-side redirect/stall controls, fetch outputs and
// the line refill handshake toward memory.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned LINE_WORDS = 4
);

  logic [ADDR_WIDTH-1:0]   branch_target;
  logic                    pc_source;
  logic                    stall;
  logic                    invalidate;

  logic                    mem_req;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_ready;
  logic [32*LINE_WORDS-1:0] mem_line;

  logic [ADDR_WIDTH-1:0]   pc;
  logic [ADDR_WIDTH-1:0]   next_pc;
  logic [31:0]             instruction;
  logic                    valid;
  logic                    hit;

  // Fetch unit side
  modport master (
    input  branch_target, pc_source, stall, invalidate, mem_ready, mem_line,
    output mem_req, mem_addr, pc, next_pc, instruction, valid, hit
  );

  // Core / memory environment side
  modport slave (
    output branch_target, pc_source, stall, invalidate, mem_ready, mem_line,
    input  mem_req, mem_addr, pc, next_pc, instruction, valid, hit
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit with a direct-mapped, read-only instruction cache.
// A miss parks the FSM in MISS and requests the whole line; the PC may be
// redirected at any time, and the in-flight refill still installs its line.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter int unsigned           LINE_WORDS = 4,
  parameter int unsigned           NUM_LINES  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic          clock,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  localparam int unsigned OFF_W   = $clog2(LINE_WORDS);
  localparam int unsigned SEL_W   = (OFF_W > 0) ? OFF_W : 1;
  localparam int unsigned IDX_W   = $clog2(NUM_LINES);
  localparam int unsigned IDX_LSB = OFF_W + 2;
  localparam int unsigned TAG_LSB = OFF_W + IDX_W + 2;
  localparam int unsigned TAG_W   = ADDR_WIDTH - TAG_LSB;
  localparam int unsigned LINE_W  = 32 * LINE_WORDS;

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_WORDS * 4 - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
  localparam logic [SEL_W-1:0]      SEL_MASK  = SEL_W'(LINE_WORDS - 1);

  typedef enum logic {
    RUN  = 1'b0,
    MISS = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic                    r_mem_req;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [NUM_LINES-1:0]    r_valid;
  logic [TAG_W-1:0]        r_tag  [NUM_LINES];
  logic [LINE_W-1:0]       r_data [NUM_LINES];

  logic [SEL_W-1:0]        w_sel;
  logic [IDX_W-1:0]        w_idx;
  logic [TAG_W-1:0]        w_tag;
  logic [IDX_W-1:0]        w_fill_idx;
  logic [TAG_W-1:0]        w_fill_tag;
  logic [LINE_W-1:0]       w_line;
  logic                    w_hit;
  logic                    w_miss_ld;
  logic                    w_install;
  logic [ADDR_WIDTH-1:0]   w_pc_inc;

  // Address split of the current pc and of the pending refill address
  assign w_sel      = SEL_W'(r_pc >> 2) & SEL_MASK;
  assign w_idx      = IDX_W'(r_pc >> IDX_LSB);
  assign w_tag      = TAG_W'(r_pc >> TAG_LSB);
  assign w_fill_idx = IDX_W'(r_mem_addr >> IDX_LSB);
  assign w_fill_tag = TAG_W'(r_mem_addr >> TAG_LSB);

  // Combinational lookup
  assign w_line   = r_data[w_idx];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_pc_inc = r_pc + ADDR_WIDTH'(4);

  assign bus.pc          = r_pc;
  assign bus.next_pc     = w_pc_inc;
  assign bus.instruction = w_line[{w_sel, 5'b00000} +: 32];
  assign bus.hit         = w_hit;
  assign bus.valid       = w_hit && (r_state == RUN);
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_addr    = r_mem_addr;

  // Next-state decode: miss detection, refill completion, abandon on invalidate
  always_comb begin
    w_state_nxt = r_state;
    w_miss_ld   = 1'b0;
    w_install   = 1'b0;
    case (r_state)
      RUN: begin
        if (!w_hit && !bus.pc_source && !bus.invalidate) begin
          w_state_nxt = MISS;
          w_miss_ld   = 1'b1;
        end
      end
      MISS: begin
        if (bus.invalidate) begin
          w_state_nxt = RUN;
        end else if (bus.mem_ready) begin
          w_state_nxt = RUN;
          w_install   = 1'b1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Refill request and line-aligned miss address, held through the whole MISS
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_mem_req <= (w_state_nxt == MISS);
      if (w_miss_ld) begin
        r_mem_addr <= r_pc & LINE_MASK;
      end
    end
  end

  // PC update: redirect beats sequential advance, which needs a valid fetch
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (bus.pc_source) begin
      r_pc <= bus.branch_target & WORD_MASK;
    end else if ((r_state == RUN) && w_hit && !bus.stall) begin
      r_pc <= w_pc_inc;
    end
  end

  // Valid bits: flash clear on reset/invalidate, set on refill install
  always_ff @(posedge clock) begin
    if (reset || bus.invalidate) begin
      r_valid <= '0;
    end else if (w_install) begin
      r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays, written only on a completed refill
  always_ff @(posedge clock) begin
    if (w_install && !reset) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= bus.mem_line;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 64: width of PC, branch target and memory address.
REQ-002 Parameter LINE_WORDS, default 4: 32-bit instructions per cache line; power of two, >=1.
REQ-003 Parameter NUM_LINES, default 16: direct-mapped cache lines; power of two, >=2.
REQ-004 Parameter RESET_PC, default 0: PC value after reset; word-aligned.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high (ports clock, reset).
REQ-006 clock  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 branch_target  in  ADDR_WIDTH  redirect address; bits [1:0] ignored, treated as 0.
REQ-009 pc_source  in  1  1 = load branch_target into PC this edge.
REQ-010 stall  in  1  downstream hold; PC not advanced.
REQ-011 invalidate  in  1  clear all cache valid bits.
REQ-012 mem_req  out  1  line refill request.
REQ-013 mem_addr  out  ADDR_WIDTH  line-aligned refill address.
REQ-014 mem_ready  in  1  mem_line valid, refill complete this cycle.
REQ-015 mem_line  in  32*LINE_WORDS  refill data; word 0 in bits [31:0] = lowest address.
REQ-016 pc  out  ADDR_WIDTH  current fetch address.
REQ-017 next_pc  out  ADDR_WIDTH  pc+4, modulo 2^ADDR_WIDTH.
REQ-018 instruction  out  32  cache word selected by pc; don't-care when valid=0.
REQ-019 valid  out  1  instruction is valid this cycle.
REQ-020 hit  out  1  cache lookup for pc hits.

Function
REQ-021 Address split SHALL be: offset = pc[log2(LINE_WORDS)+1:2], index = next log2(NUM_LINES) bits, tag = remaining upper bits.
REQ-022 Lookup SHALL be combinational from the pc register and cache arrays; hit = valid bit[index] and stored tag == tag.
REQ-023 FSM SHALL have two states: RUN, MISS.
REQ-024 valid SHALL equal hit AND state==RUN; hit is reported in either state, valid only in RUN.
REQ-025 PC update priority per edge: reset > pc_source > (RUN and hit and not stall: pc <= pc+4) > hold.
REQ-026 RUN -> MISS when not hit, pc_source=0, invalidate=0; miss_addr latched as pc with offset and bits[1:0] zeroed.
REQ-027 RUN with pc_source=1 SHALL stay RUN regardless of hit; no request issued for the old pc.
REQ-028 In MISS, mem_req SHALL be 1 and mem_addr SHALL equal miss_addr, held constant until mem_ready.
REQ-029 MISS with mem_ready=1 SHALL write mem_line, tag and valid=1 into line index(miss_addr) and return to RUN; mem_req low next cycle.
REQ-030 Miss penalty: first fetch of a missing line is valid 1 cycle after the mem_ready cycle.
REQ-031 pc_source during MISS SHALL update pc immediately; refill continues and installs the line for miss_addr; lookup resumes on new pc in RUN.
REQ-032 invalidate SHALL clear all valid bits at the edge; in MISS it also abandons the refill (no install, state -> RUN); invalidate with mem_ready in the same cycle: invalidate wins, line not installed.
REQ-033 Refill replaces the existing line at the index unconditionally (no write-back, read-only cache).
REQ-034 stall SHALL not block the FSM; a miss is serviced while stalled.
REQ-035 pc+4 SHALL wrap from all-ones-minus-3 to 0 without error.
REQ-036 mem_req dropped without mem_ready (reset/invalidate) means the request is abandoned; memory SHALL tolerate this.

Reset
REQ-037 reset SHALL set pc=RESET_PC, state=RUN, all valid bits 0, mem_req=0, mem_addr=0; hence valid=0, hit=0, next_pc=RESET_PC+4.
REQ-038 Reset mid-MISS SHALL abandon the refill; a coincident mem_ready SHALL not install the line.
REQ-039 Tag/data arrays need not be reset.

Verification
REQ-040 Cold start: reset, RESET_PC=0, mem_ready after 3 cycles with words A0..A3 -> mem_req=1, mem_addr=0; valid=1, instruction=A0 one cycle after mem_ready; then A1,A2,A3 on consecutive cycles, next miss at 0x10.
REQ-041 Stall: hit at pc=0x4, stall=1 for 2 cycles -> pc stays 0x4, valid=1, instruction unchanged; advances to 0x8 after release.
REQ-042 Redirect during MISS: miss at 0x40, pc_source=1 with target 0x0 (cached) -> pc=0x0 next cycle, valid=0 until mem_ready; line 0x40 installed, later fetch of 0x40 hits with no mem_req.
REQ-043 Conflict: NUM_LINES=16, LINE_WORDS=4, fetch 0x0 then 0x100 -> second miss evicts first; return to 0x0 issues mem_req, mem_addr=0x0.
REQ-044 Invalidate + mem_ready same cycle -> line not installed, state RUN, re-fetch issues new mem_req.
REQ-045 Wrap: pc=2^ADDR_WIDTH-4 hit, no stall -> next_pc=0, pc=0 next edge.
